// File: rtl/led_ctrl_pkg.sv
// Shared mode encodings and field widths for the LED mode controller.
package led_ctrl_pkg;

    localparam int LED_IDX_W = 2;
    localparam int RATE_W    = 4;

    localparam logic [1:0] MODE_OFF   = 2'd0;
    localparam logic [1:0] MODE_ON    = 2'd1;
    localparam logic [1:0] MODE_BLINK = 2'd2;
    localparam logic [1:0] MODE_PWM   = 2'd3;

endpackage

// File: rtl/led_channel.sv
// One LED channel: holds its mode/rate, runs its blink divider and drives a
// registered LED bit from the current mode.
module led_channel
    import led_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [1:0]        mode,
    input  logic [RATE_W-1:0] rate,
    input  logic              tick,
    input  logic [RATE_W-1:0] phase,
    output logic              led
);

    logic [1:0]        mode_q;
    logic [RATE_W-1:0] rate_q;
    logic [RATE_W-1:0] blink_cnt;
    logic              blink_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_OFF;
            rate_q      <= '0;
            blink_cnt   <= '0;
            blink_state <= 1'b0;
            led         <= 1'b0;
        end else begin
            // Output uses the pre-load settings, so a new mode shows one cycle later.
            case (mode_q)
                MODE_OFF:   led <= 1'b0;
                MODE_ON:    led <= 1'b1;
                MODE_BLINK: led <= blink_state;
                MODE_PWM:   led <= (phase < rate_q);
            endcase

            if (load) begin
                mode_q      <= mode;
                rate_q      <= rate;
                blink_cnt   <= '0;
                blink_state <= 1'b0;
            end else if (mode_q == MODE_BLINK && tick) begin
                if (blink_cnt == rate_q) begin
                    blink_cnt   <= '0;
                    blink_state <= ~blink_state;
                end else begin
                    blink_cnt <= blink_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// LED mode controller: command handshake, load decode, blink tick prescaler
// and shared PWM phase feeding NUM_LED independent channels.
module led_mode_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000,
    parameter int NUM_LED  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [LED_IDX_W-1:0] cmd_led,
    input  logic [1:0]           cmd_mode,
    input  logic [RATE_W-1:0]    cmd_rate,
    output logic [NUM_LED-1:0]   led
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [PRE_W-1:0]   pre_cnt;
    logic [RATE_W-1:0]  phase;
    logic               tick;
    logic               accept;
    logic [NUM_LED-1:0] load;

    // valid/ready: a command transfers at an edge where both are high; ready then
    // drops for exactly one cycle, and inputs are ignored while ready is low.
    assign accept = cmd_valid && cmd_ready;
    assign tick   = (pre_cnt == PRE_W'(TICK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b0;
            pre_cnt   <= '0;
            phase     <= '0;
        end else begin
            cmd_ready <= !accept;
            pre_cnt   <= tick ? '0 : pre_cnt + 1'b1;
            phase     <= phase + 1'b1;
        end
    end

    for (genvar i = 0; i < NUM_LED; i++) begin : g_ch
        assign load[i] = accept && (cmd_led == LED_IDX_W'(i));

        led_channel u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .load  (load[i]),
            .mode  (cmd_mode),
            .rate  (cmd_rate),
            .tick  (tick),
            .phase (phase),
            .led   (led[i])
        );
    end

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl with an arithmetic reference model.
module tb_led_mode_ctrl;

    localparam int TICK_DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_led = '0;
    logic [1:0] cmd_mode = '0;
    logic [3:0] cmd_rate = '0;
    logic [3:0] led;

    int n_cmp = 0;
    int n_err = 0;

    led_mode_ctrl #(.TICK_DIV(TICK_DIV), .NUM_LED(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_led   (cmd_led),
        .cmd_mode  (cmd_mode),
        .cmd_rate  (cmd_rate),
        .led       (led)
    );

    always #5 clk = ~clk;

    // Edges counted since reset release; edge 1 is the first one.
    int edge_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edge_cnt <= 0;
        else        edge_cnt <= edge_cnt + 1;
    end

    typedef struct {
        logic [1:0] mode;
        logic [3:0] rate;
        int         load_edge;
    } cfg_t;

    cfg_t cur[4];
    cfg_t prev[4];
    int   last_acc;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            cur[i]  = '{mode: 2'd0, rate: 4'd0, load_edge: 0};
            prev[i] = cur[i];
        end
        last_acc = -1;
    endfunction

    function automatic bit model_ready();
        return (edge_cnt >= 1) && (last_acc != edge_cnt);
    endfunction

    // Blink ticks land in the cycle before edges that are multiples of TICK_DIV.
    function automatic int ticks_in(int a, int b);
        if (b < a) return 0;
        return b / TICK_DIV - (a - 1) / TICK_DIV;
    endfunction

    // LED value visible after edge k, from the rules rather than the registers.
    function automatic logic exp_bit(int ch, int k);
        cfg_t c;
        int   t;
        c = (cur[ch].load_edge < k) ? cur[ch] : prev[ch];
        case (c.mode)
            2'd0: return 1'b0;
            2'd1: return 1'b1;
            2'd3: return ((k - 1) % 16) < int'(c.rate);
            default: begin
                t = ticks_in(c.load_edge + 1, k - 1);
                return ((t / (int'(c.rate) + 1)) % 2) == 1;
            end
        endcase
    endfunction

    // Advance one edge from a negedge, update the model, check at the next negedge.
    task automatic step(output bit acc);
        int         k;
        logic [3:0] exp_led;
        k   = edge_cnt + 1;
        acc = cmd_valid && model_ready();
        @(posedge clk);
        if (acc) begin
            prev[cmd_led] = cur[cmd_led];
            cur[cmd_led]  = '{mode: cmd_mode, rate: cmd_rate, load_edge: k};
            last_acc      = k;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++) exp_led[i] = exp_bit(i, k);
        n_cmp++;
        if (led !== exp_led) begin
            n_err++;
            $display("FAIL led edge=%0d got=%b exp=%b", k, led, exp_led);
        end
        n_cmp++;
        if (cmd_ready !== (last_acc != k)) begin
            n_err++;
            $display("FAIL cmd_ready edge=%0d got=%b exp=%b", k, cmd_ready, last_acc != k);
        end
    endtask

    task automatic run(int n);
        bit a;
        for (int i = 0; i < n; i++) step(a);
    endtask

    task automatic send_cmd(logic [1:0] l, logic [1:0] m, logic [3:0] r);
        bit a;
        int tries;
        cmd_valid = 1'b1; cmd_led = l; cmd_mode = m; cmd_rate = r;
        a = 1'b0;
        tries = 0;
        while (!a && tries < 4) begin
            step(a);
            tries++;
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (!a) begin
            n_err++;
            $display("FAIL send_cmd timeout got=not_accepted exp=accepted");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (led !== 4'b0000 || cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_hold got=%b/%b exp=0000/0", led, cmd_ready);
        end
        rst_n = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL ready_before_edge got=%b exp=0", cmd_ready);
        end
        run(3);
    endtask

    task automatic test_on_handshake();
        bit a;
        cmd_valid = 1'b1; cmd_led = 2'd2; cmd_mode = 2'd1; cmd_rate = 4'($urandom_range(0, 15));
        step(a);
        n_cmp++;
        if (!a) begin
            n_err++;
            $display("FAIL on_accept got=0 exp=1");
        end
        cmd_led = 2'd1; cmd_mode = 2'd1;
        step(a);
        n_cmp++;
        if (led !== 4'b0100 || a) begin
            n_err++;
            $display("FAIL busy_cycle led=%b got_acc=%b exp=0100/0", led, a);
        end
        step(a);
        cmd_valid = 1'b0;
        n_cmp++;
        if (!a) begin
            n_err++;
            $display("FAIL second_accept got=0 exp=1");
        end
        run(2);
        n_cmp++;
        if (led !== 4'b0110) begin
            n_err++;
            $display("FAIL on_both got=%b exp=0110", led);
        end
        send_cmd(2'd1, 2'd0, 4'd0);
        send_cmd(2'd2, 2'd0, 4'd0);
        run(2);
    endtask

    task automatic test_blink();
        int rises;
        logic last;
        send_cmd(2'd0, 2'd2, 4'd1);
        rises = 0;
        last  = led[0];
        for (int i = 0; i < 50; i++) begin
            run(1);
            if (led[0] && !last) rises++;
            last = led[0];
        end
        n_cmp++;
        if (rises !== 3) begin
            n_err++;
            $display("FAIL blink_rises got=%0d exp=3", rises);
        end
        send_cmd(2'd0, 2'd0, 4'd0);
        run(2);
    endtask

    task automatic test_pwm();
        logic [3:0] rates[3] = '{4'd4, 4'd0, 4'd15};
        int lit;
        for (int r = 0; r < 3; r++) begin
            send_cmd(2'd1, 2'd3, rates[r]);
            lit = 0;
            for (int i = 0; i < 16; i++) begin
                run(1);
                if (led[1]) lit++;
            end
            n_cmp++;
            if (lit !== int'(rates[r])) begin
                n_err++;
                $display("FAIL pwm_duty rate=%0d got=%0d exp=%0d", rates[r], lit, rates[r]);
            end
        end
        send_cmd(2'd1, 2'd0, 4'd0);
        run(2);
    endtask

    task automatic test_collision();
        bit a;
        int guard;
        send_cmd(2'd3, 2'd2, 4'd0);
        run(5);
        guard = 0;
        while ((((edge_cnt + 1) % TICK_DIV) != 0 || !model_ready()) && guard < 20) begin
            run(1);
            guard++;
        end
        cmd_valid = 1'b1; cmd_led = 2'd3; cmd_mode = 2'd0; cmd_rate = 4'd0;
        step(a);
        cmd_valid = 1'b0;
        run(1);
        n_cmp++;
        if (led[3] !== 1'b0 || !a) begin
            n_err++;
            $display("FAIL collision led3=%b acc=%b exp=0/1", led[3], a);
        end
        run(8);
    endtask

    task automatic test_random();
        bit a;
        for (int i = 0; i < 800; i++) begin
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_led   = 2'($urandom_range(0, 3));
            cmd_mode  = 2'($urandom_range(0, 3));
            cmd_rate  = 4'($urandom_range(0, 15));
            step(a);
        end
        cmd_valid = 1'b0;
        run(4);
    endtask

    task automatic test_mid_reset();
        send_cmd(2'd0, 2'd1, 4'd0);
        send_cmd(2'd1, 2'd2, 4'd0);
        send_cmd(2'd2, 2'd3, 4'd9);
        send_cmd(2'd3, 2'd2, 4'd2);
        run(21);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        n_cmp++;
        if (led !== 4'b0000 || cmd_ready !== 1'b0) begin
            n_err++;
            $display("FAIL mid_reset got=%b/%b exp=0000/0", led, cmd_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        run(40);
        n_cmp++;
        if (led !== 4'b0000) begin
            n_err++;
            $display("FAIL after_reset got=%b exp=0000", led);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_on_handshake();
        test_blink();
        test_pwm();
        test_collision();
        test_random();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
